// File: rtl/sum_acc_pkg.sv
// Shared state encoding and default sizing for the sum accumulator slice.
package sum_acc_pkg;

  typedef enum logic {
    ACCUM = 1'b0,
    DONE  = 1'b1
  } state_t;

  localparam int unsigned SUM_W_DEF = 30;
  localparam int unsigned ACC_W_DEF = 32;
  localparam int unsigned BEATS_DEF = 8;

endpackage

// File: rtl/acc_add_sat.sv
// ACC_W-wide accumulate adder with carry-out.
// Build option: define SUM_ACC_SAT_EN to saturate instead of wrapping.
module acc_add_sat
  import sum_acc_pkg::*;
#(
  parameter int unsigned ACC_W = ACC_W_DEF
) (
  input  logic [ACC_W-1:0] acc,
  input  logic [ACC_W-1:0] addend,
  output logic [ACC_W-1:0] acc_nxt,
  output logic             carry
);

  logic [ACC_W:0] full;

  assign full  = {1'b0, acc} + {1'b0, addend};
  assign carry = full[ACC_W];

`ifdef SUM_ACC_SAT_EN
  // Once pinned at all-ones any non-zero addend carries again, so saturation holds.
  assign acc_nxt = carry ? '1 : full[ACC_W-1:0];
`else
  assign acc_nxt = full[ACC_W-1:0];
`endif

endmodule

// File: rtl/sum_accumulator.sv
// Folds BEATS upstream adder sums into one ACC_W result with a sticky overflow flag.
// Overflow policy selected by SUM_ACC_SAT_EN inside acc_add_sat.
module sum_accumulator
  import sum_acc_pkg::*;
#(
  parameter int unsigned SUM_W = SUM_W_DEF,
  parameter int unsigned ACC_W = ACC_W_DEF,
  parameter int unsigned BEATS = BEATS_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [SUM_W-1:0] in_sum,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_acc,
  output logic             out_ovf
);

  localparam int unsigned     CNT_W = $clog2(BEATS + 1);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(BEATS - 1);

  state_t           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_nxt, sum_ext;
  logic [CNT_W-1:0] cnt_q;
  logic             ovf_q, carry, rdy_q;
  logic             accept, last_beat, handshake;

  assign sum_ext   = ACC_W'(in_sum);
  // rdy_q keeps in_ready low until the first edge after reset release
  assign in_ready  = rdy_q && (state_q == ACCUM);
  assign out_valid = (state_q == DONE);
  assign out_acc   = out_valid ? acc_q : '0;
  assign out_ovf   = out_valid && ovf_q;

  assign accept    = in_valid && in_ready;
  assign last_beat = accept && (cnt_q == LAST);
  assign handshake = out_valid && out_ready;

  acc_add_sat #(
    .ACC_W (ACC_W)
  ) u_add (
    .acc     (acc_q),
    .addend  (sum_ext),
    .acc_nxt (acc_nxt),
    .carry   (carry)
  );

  always_comb begin
    state_d = state_q;
    if (clr) begin
      state_d = ACCUM;
    end else begin
      case (state_q)
        ACCUM:   if (last_beat) state_d = DONE;
        DONE:    if (out_ready) state_d = ACCUM;
        default: state_d = ACCUM;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ACCUM;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_q <= 1'b0;
      acc_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      rdy_q <= 1'b1;
      if (clr || handshake) begin
        acc_q <= '0;
        cnt_q <= '0;
        ovf_q <= 1'b0;
      end else if (accept) begin
        acc_q <= acc_nxt;
        ovf_q <= ovf_q | carry;
        cnt_q <= last_beat ? '0 : cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sum_accumulator.sv
// Self-checking bench: true-sum reference model compared every cycle, plus literal pins.
module tb_sum_accumulator;

  localparam int unsigned SUM_W = 30;
  localparam int unsigned ACC_W = 32;
  localparam int unsigned BEATS = 8;
  localparam longint unsigned LIM = 64'h1_0000_0000;
`ifdef SUM_ACC_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n, clr, in_valid, in_ready, out_valid, out_ready, out_ovf;
  logic [SUM_W-1:0] in_sum;
  logic [ACC_W-1:0] out_acc;

  int nerr = 0;
  int nchk = 0;

  sum_accumulator #(.SUM_W(SUM_W), .ACC_W(ACC_W), .BEATS(BEATS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sum    (in_sum),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_acc   (out_acc),
    .out_ovf   (out_ovf)
  );

  always #5 clk = ~clk;

  // Reference model: true (unbounded) sum and beat tally of the current result.
  longint unsigned m_sum;
  int unsigned     m_n, m_res;
  bit              m_rdy;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_sum <= 0;
      m_n   <= 0;
      m_rdy <= 1'b0;
    end else begin
      m_rdy <= 1'b1;
      if (clr) begin
        m_sum <= 0;
        m_n   <= 0;
      end else if (m_n == BEATS) begin
        if (out_ready) begin
          m_sum <= 0;
          m_n   <= 0;
          m_res <= m_res + 1;
        end
      end else if (m_rdy && in_valid) begin
        m_sum <= m_sum + longint'(in_sum);
        m_n   <= m_n + 1;
      end
    end
  end

  function automatic logic [ACC_W-1:0] exp_acc();
    if (m_n != BEATS) return '0;
    if (SAT && m_sum >= LIM) return '1;
    return m_sum[ACC_W-1:0];
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    nchk++;
    if (act !== req) begin
      nerr++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("in_ready",  64'(in_ready),  64'(m_rdy && m_n != BEATS));
    chk("out_valid", 64'(out_valid), 64'(m_n == BEATS));
    chk("out_acc",   64'(out_acc),   64'(exp_acc()));
    chk("out_ovf",   64'(out_ovf),   64'(m_n == BEATS && m_sum >= LIM));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one beat and hold in_valid until it is taken.
  task automatic beat(input logic [SUM_W-1:0] v);
    bit taken = 1'b0;
    in_valid = 1'b1;
    in_sum   = v;
    for (int i = 0; i < 50 && !taken; i++) begin
      taken = in_ready;
      step();
    end
    if (!taken) begin
      nerr++;
      $display("FAIL beat_timeout actual=not_accepted required=accepted");
    end
  endtask

  task automatic beats(input int n, input logic [SUM_W-1:0] v);
    for (int i = 0; i < n; i++) beat(v);
  endtask

  task automatic take_result();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  initial begin
    int unsigned base, cyc;
    rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_sum = '0;
    m_res = 0;
    #22;
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_out_acc",  64'(out_acc),  64'd0);
    step();
    rst_n = 1'b1;
    chk("post_rst_ready_low", 64'(in_ready), 64'd0);
    step();
    chk("ready_after_edge", 64'(in_ready), 64'd1);

    beats(8, 30'd1);
    chk("r023_valid", 64'(out_valid), 64'd1);
    chk("r023_acc",   64'(out_acc),   64'd8);
    chk("r023_ovf",   64'(out_ovf),   64'd0);
    chk("r023_ready", 64'(in_ready),  64'd0);
    take_result();

    beats(8, 30'h3FFF_FFFF);
    for (int i = 0; i < 5; i++) begin
      chk("r024_acc", 64'(out_acc), SAT ? 64'hFFFF_FFFF : 64'hFFFF_FFF8);
      chk("r024_ovf", 64'(out_ovf), 64'd1);
      chk("r025_ready", 64'(in_ready), 64'd0);
      step();
    end
    take_result();
    chk("r025_cleared", 64'(out_valid), 64'd0);
    beats(8, 30'd5);
    chk("r025_next_acc", 64'(out_acc), 64'd40);
    take_result();

    beats(4, 30'd2);
    in_valid = 1'b1; in_sum = 30'd2; clr = 1'b1;
    step();
    clr = 1'b0; in_valid = 1'b0;
    chk("r026_no_valid", 64'(out_valid), 64'd0);
    beats(8, 30'd2);
    chk("r026_acc", 64'(out_acc), 64'd16);
    take_result();

    beats(3, 30'd3);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("r027_ready", 64'(in_ready),  64'd0);
    chk("r027_valid", 64'(out_valid), 64'd0);
    chk("r027_acc",   64'(out_acc),   64'd0);
    step();
    rst_n = 1'b1;
    step();
    beats(8, 30'd3);
    chk("r027_acc24", 64'(out_acc), 64'd24);
    take_result();

    base = m_res;
    cyc  = 0;
    while (m_res < base + 1000 && cyc < 60000) begin
      in_valid  = ($urandom_range(3) != 0);
      out_ready = ($urandom_range(4) > 1);
      in_sum    = ($urandom_range(3) == 0) ? 30'h3FFF_FFFF - SUM_W'($urandom_range(255))
                                           : SUM_W'($urandom);
      clr       = ($urandom_range(299) == 0);
      step();
      cyc++;
    end
    in_valid = 1'b0; out_ready = 1'b0; clr = 1'b0;
    chk("r028_results", 64'(m_res - base >= 1000), 64'd1);
    step();

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
